// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: scans NUM_DIGITS common-anode digits through one shared
// hex-to-7-segment decoder. A pending value is committed to a shadow copy
// only at frame wrap or on leaving IDLE, so a frame never shows a mix of
// old and new digits. Each digit is lit for DWELL_CYC cycles and followed by
// GAP_CYC cycles with all anodes off.
//
// Ports:
//   clk, rst    rising-edge clock, async active-high reset
//   en          scanning permitted (0 = display dark, scan returns to IDLE)
//   load/value  1-cycle request to show value (nibble i = digit i, 0 = right)
//   blank_mask  force digit i dark; its time slot is still spent
//   lz_en       suppress leading zeros (digit 0 is never suppressed)
//   load_ack    1-cycle pulse when a pending value enters the shadow
//   nibble      decoder input
//   an_n        active-low anode strobes, at most one low
//   frame_done  1-cycle pulse on the last-digit -> digit-0 wrap

// Per-digit darkness. zero_above/zero_from form a ripple chain from the
// most significant digit down, marking "this and every higher nibble is 0".
module seg7_lane_dark #(
  parameter int LANE = 0
) (
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       lz_en,
  input  logic       zero_above,
  output logic       zero_from,
  output logic       dark
);
  assign zero_from = zero_above & (nib == 4'h0);
  assign dark      = blank | (lz_en & (LANE != 0) & zero_from);
endmodule

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL_CYC  = 50000,
  parameter int GAP_CYC    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  input  logic                      lz_en,
  output logic                      load_ack,
  output logic [3:0]                nibble,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      frame_done
);
  localparam int MAXC = (DWELL_CYC > GAP_CYC) ? ((DWELL_CYC > 2) ? DWELL_CYC : 2)
                                              : ((GAP_CYC > 2) ? GAP_CYC : 2);
  localparam int CW = $clog2(MAXC);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam bit NO_GAP = (GAP_CYC == 0);
  localparam logic [CW-1:0] DW_LAST  = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] GP_LAST  = CW'(NO_GAP ? 0 : GAP_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, LIT, GAP} state_t;

  state_t                        state;
  logic [IW-1:0]                 idx;
  logic [CW-1:0]                 cnt;
  logic [NUM_DIGITS-1:0][3:0]    shadow;
  logic [NUM_DIGITS-1:0][3:0]    pend;
  logic                          pend_v;
  logic                          shadow_v;   // shadow holds a loaded value
  logic [NUM_DIGITS-1:0]         dark;
  logic [NUM_DIGITS:0]           zs;
  logic                          adv;

  assign zs[NUM_DIGITS] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    seg7_lane_dark #(.LANE(i)) u_lane (
      .nib        (shadow[i]),
      .blank      (blank_mask[i]),
      .lz_en      (lz_en),
      .zero_above (zs[i+1]),
      .zero_from  (zs[i]),
      .dark       (dark[i])
    );
  end

  // Slot finished: end of GAP, or end of LIT when there is no gap state.
  assign adv = en && ((state == LIT && cnt == DW_LAST && NO_GAP) ||
                      (state == GAP && cnt == GP_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      shadow_v   <= 1'b0;
      an_n       <= '1;
      nibble     <= 4'h0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      load_ack   <= 1'b0;
      frame_done <= 1'b0;

      // Outputs follow the current state/idx one cycle later; en=0 darkens
      // immediately so a dropped enable never leaves a digit lit.
      if (en && state == LIT) begin
        nibble <= shadow[idx];
        an_n   <= dark[idx] ? '1 : ~(NUM_DIGITS'(1) << idx);
      end else begin
        an_n   <= '1;
      end

      if (!en) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt <= '0;
            if (pend_v) begin
              shadow   <= pend;
              pend_v   <= 1'b0;
              shadow_v <= 1'b1;
              load_ack <= 1'b1;
              state    <= LIT;
              idx      <= '0;
            end else if (shadow_v) begin
              state <= LIT;
              idx   <= '0;
            end
          end
          LIT: begin
            if (cnt == DW_LAST) begin
              cnt   <= '0;
              state <= NO_GAP ? LIT : GAP;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          GAP: begin
            if (cnt == GP_LAST) begin
              cnt   <= '0;
              state <= LIT;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase

        if (adv) begin
          if (idx == LAST_IDX) begin
            idx        <= '0;
            frame_done <= 1'b1;
            if (pend_v) begin
              shadow   <= pend;
              pend_v   <= 1'b0;
              load_ack <= 1'b1;
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end
      end

      // Placed last so a load in a commit cycle stays pending for the next one.
      if (load) begin
        pend   <= value;
        pend_v <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (GAP_CYC=2 and GAP_CYC=0) share
// stimulus. A frame-position model predicts every output each cycle; a table
// of display vectors and a few hand sequences check exact frame contents.
module tb_seg7_scan_ctrl;
  localparam int ND = 4;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, load = 1'b0, lz_en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '0;
  logic        ack_g, fd_g, ack_z, fd_z;
  logic [3:0]  nib_g, an_g, nib_z, an_z;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYC(DW), .GAP_CYC(2)) dut_g (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .blank_mask(blank_mask), .lz_en(lz_en), .load_ack(ack_g),
    .nibble(nib_g), .an_n(an_g), .frame_done(fd_g));

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYC(DW), .GAP_CYC(0)) dut_z (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .blank_mask(blank_mask), .lz_en(lz_en), .load_ack(ack_z),
    .nibble(nib_z), .an_n(an_z), .frame_done(fd_z));

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  // Model: pos is the cycle offset within the frame; slot and lit/gap fall
  // out of plain division by the slot length.
  typedef struct {
    bit run; bit sv; bit pv; int pos;
    logic [15:0] sh; logic [15:0] pd;
    logic [3:0] an; logic [3:0] nib; bit ack; bit fd;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t m;
    m.run = 0; m.sv = 0; m.pv = 0; m.pos = 0; m.sh = '0; m.pd = '0;
    m.an = 4'hF; m.nib = 4'h0; m.ack = 0; m.fd = 0;
    return m;
  endfunction

  function automatic bit is_dark(logic [15:0] sh, int s, logic [3:0] bm, bit lz);
    return bm[s] || (lz && s != 0 && (sh >> (4*s)) == 16'h0);
  endfunction

  function automatic mdl_t mstep(mdl_t m, int g, bit en_i, bit ld, logic [15:0] v,
                                 logic [3:0] bm, bit lz);
    mdl_t n = m;
    int slen = DW + g;
    int s = m.pos / slen;
    n.ack = 0; n.fd = 0;
    if (en_i && m.run && (m.pos % slen) < DW) begin
      n.nib = 4'(m.sh >> (4*s));
      n.an  = is_dark(m.sh, s, bm, lz) ? 4'hF : ~(4'b0001 << s);
    end else n.an = 4'hF;
    if (!en_i) begin
      n.run = 0; n.pos = 0;
    end else if (!m.run) begin
      if (m.pv) begin
        n.sh = m.pd; n.pv = 0; n.sv = 1; n.ack = 1; n.run = 1; n.pos = 0;
      end else if (m.sv) begin
        n.run = 1; n.pos = 0;
      end
    end else begin
      n.pos = m.pos + 1;
      if (n.pos == ND*slen) begin
        n.pos = 0; n.fd = 1;
        if (m.pv) begin n.sh = m.pd; n.pv = 0; n.ack = 1; end
      end
    end
    if (ld) begin n.pd = v; n.pv = 1; end
    return n;
  endfunction

  mdl_t mg, mz;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mg <= mreset(); mz <= mreset();
    end else begin
      mg <= mstep(mg, 2, en, load, value, blank_mask, lz_en);
      mz <= mstep(mz, 0, en, load, value, blank_mask, lz_en);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_an_g",  16'(an_g),  16'(mg.an));
      chk("m_nib_g", 16'(nib_g), 16'(mg.nib));
      chk("m_ack_g", 16'(ack_g), 16'(mg.ack));
      chk("m_fd_g",  16'(fd_g),  16'(mg.fd));
      chk("m_an_z",  16'(an_z),  16'(mz.an));
      chk("m_nib_z", 16'(nib_z), 16'(mz.nib));
      chk("m_ack_z", 16'(ack_z), 16'(mz.ack));
      chk("m_fd_z",  16'(fd_z),  16'(mz.fd));
      chk("onehot_g", 16'($countones(~an_g) <= 1), 16'(1));
      chk("onehot_z", 16'($countones(~an_z) <= 1), 16'(1));
    end
  end

  typedef struct {
    logic [15:0] v; logic [3:0] bm; bit lz;
    logic [3:0] an [4]; logic [3:0] nib [4];
  } vec_t;
  vec_t tbl [6];

  // Called at the negedge right after a commit edge; checks mid-dwell of
  // each slot on the GAP_CYC=2 instance and the 24-cycle frame period.
  task automatic frame_chk(int vi);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c % 6 == 2) begin
        chk($sformatf("v%0d_an_slot%0d", vi, c/6), 16'(an_g), 16'(tbl[vi].an[c/6]));
        chk($sformatf("v%0d_nib_slot%0d", vi, c/6), 16'(nib_g), 16'(tbl[vi].nib[c/6]));
      end
    end
    chk($sformatf("v%0d_frame_period", vi), 16'(fd_g), 16'(1));
  endtask

  task automatic wait_fd(string nm);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (fd_g) seen = 1;
    end
    if (!seen) chk({nm, "_timeout"}, 16'(0), 16'(1));
  endtask

  initial begin
    tbl[0] = '{16'h12AF, 4'b0000, 0, '{4'hE,4'hD,4'hB,4'h7}, '{4'hF,4'hA,4'h2,4'h1}};
    tbl[1] = '{16'h0000, 4'b0000, 1, '{4'hE,4'hF,4'hF,4'hF}, '{4'h0,4'h0,4'h0,4'h0}};
    tbl[2] = '{16'h0305, 4'b0000, 1, '{4'hE,4'hD,4'hB,4'hF}, '{4'h5,4'h0,4'h3,4'h0}};
    tbl[3] = '{16'h1234, 4'b0101, 0, '{4'hF,4'hD,4'hF,4'h7}, '{4'h4,4'h3,4'h2,4'h1}};
    tbl[4] = '{16'h0042, 4'b0000, 0, '{4'hE,4'hD,4'hB,4'h7}, '{4'h2,4'h4,4'h0,4'h0}};
    tbl[5] = '{16'h2222, 4'b0000, 0, '{4'hE,4'hD,4'hB,4'h7}, '{4'h2,4'h2,4'h2,4'h2}};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_an", 16'(an_g), 16'hF);
    chk("rst_nib", 16'(nib_g), 16'h0);
    chk("rst_ack", 16'(ack_g), 16'h0);
    chk("rst_fd", 16'(fd_g), 16'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_shadow_an", 16'(an_g), 16'hF);

    // first load from IDLE: ack on the cycle after capture
    en = 1'b1; load = 1'b1; value = tbl[0].v;
    @(negedge clk); load = 1'b0;
    chk("first_ack_early", 16'(ack_g), 16'h0);
    @(negedge clk);
    chk("first_ack", 16'(ack_g), 16'h1);
    frame_chk(0);

    // table: load mid-frame, commit lands on the wrap with frame_done
    for (int i = 1; i <= 4; i++) begin
      repeat (7) @(negedge clk);
      value = tbl[i].v; blank_mask = tbl[i].bm; lz_en = tbl[i].lz; load = 1'b1;
      @(negedge clk); load = 1'b0;
      wait_fd($sformatf("v%0d_wrap", i));
      chk($sformatf("v%0d_ack_at_wrap", i), 16'(ack_g), 16'h1);
      frame_chk(i);
    end

    // en dropped during digit 2, then re-raised: restart at digit 0, no ack
    repeat (14) @(negedge clk);
    chk("en_drop_pre_an", 16'(an_g), 16'hB);
    en = 1'b0;
    @(negedge clk);
    chk("en_drop_an", 16'(an_g), 16'hF);
    repeat (4) @(negedge clk);
    chk("en_low_an", 16'(an_g), 16'hF);
    en = 1'b1;
    @(negedge clk);
    chk("en_restart_ack", 16'(ack_g), 16'h0);
    frame_chk(4);

    // two loads in one frame merge into one ack at the wrap
    begin
      int acks = 0;
      bit seen = 0;
      repeat (3) @(negedge clk);
      value = 16'h1111; load = 1'b1;
      @(negedge clk); load = 1'b0;
      repeat (5) @(negedge clk);
      value = 16'h2222; load = 1'b1;
      @(negedge clk); load = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (ack_g) acks++;
        if (fd_g) seen = 1;
      end
      chk("merged_ack_count", 16'(acks), 16'h1);
      frame_chk(5);
    end

    // GAP_CYC=0 instance: frame period is ND*DW
    begin
      int n = 0;
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (fd_z) seen = 1;
      end
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        n++;
        if (fd_z) seen = 1;
      end
      chk("gap0_period", 16'(n), 16'd16);
    end

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      en    = ($urandom_range(0, 39) != 0);
      load  = ($urandom_range(0, 9) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 63) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 63) == 0) lz_en = 1'($urandom);
    end
    load = 1'b0; en = 1'b1; blank_mask = '0;

    // reset mid-scan: anodes dark at once, pending load lost
    value = 16'h5A5A; load = 1'b1;
    @(negedge clk); load = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_an_g", 16'(an_g), 16'hF);
    chk("midrst_an_z", 16'(an_z), 16'hF);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_dark", 16'(an_g), 16'hF);
    chk("post_rst_no_ack", 16'(ack_g), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
